// File: rtl/count_reader_if.sv
// Bus-side signals of one counter channel's read-back path.
interface count_reader_if;
  logic [15:0] count;
  logic        mode_wr;
  logic [1:0]  rw;
  logic        rd;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        latched;

  modport master (output count, mode_wr, rw, rd, input dout, dout_valid, latched);
  modport slave  (input count, mode_wr, rw, rd, output dout, dout_valid, latched);
endinterface

// File: rtl/count_reader.sv
// Counter read-back: latch command, byte pointer and LSB/MSB read sequencing.
module count_reader (
  input  logic          clk,
  input  logic          rst_n,
  count_reader_if.slave bus
);
  typedef enum logic {PTR_LSB = 1'b0, PTR_MSB = 1'b1} ptr_t;

  ptr_t        ptr_q, ptr_d;
  logic [1:0]  rw_mode_q, rw_mode_d;
  logic [15:0] latch_q, latch_d;
  logic        flag_q, flag_d;
  logic [7:0]  dout_q, dout_d;
  logic        vld_q, vld_d;
  logic [15:0] src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_LSB;
      rw_mode_q <= 2'b11;
      latch_q   <= 16'h0000;
      flag_q    <= 1'b0;
      dout_q    <= 8'h00;
      vld_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rw_mode_q <= rw_mode_d;
      latch_q   <= latch_d;
      flag_q    <= flag_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
    end
  end

  assign src = flag_q ? latch_q : bus.count;

  always_comb begin
    ptr_d     = ptr_q;
    rw_mode_d = rw_mode_q;
    latch_d   = latch_q;
    flag_d    = flag_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    // A control write wins over a coincident read; the read is dropped.
    if (bus.mode_wr) begin
      if (bus.rw != 2'b00) begin
        rw_mode_d = bus.rw;
        ptr_d     = PTR_LSB;
        flag_d    = 1'b0;
      end else if (!flag_q) begin
        latch_d = bus.count;
        flag_d  = 1'b1;
      end
    end else if (bus.rd) begin
      vld_d = 1'b1;
      case (rw_mode_q)
        2'b01: begin
          dout_d = src[7:0];
          ptr_d  = PTR_LSB;
          flag_d = 1'b0;
        end
        2'b10: begin
          dout_d = src[15:8];
          ptr_d  = PTR_LSB;
          flag_d = 1'b0;
        end
        default: begin
          if (ptr_q == PTR_LSB) begin
            dout_d = src[7:0];
            ptr_d  = PTR_MSB;
          end else begin
            dout_d = src[15:8];
            ptr_d  = PTR_LSB;
            flag_d = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.latched    = flag_q;
endmodule

// File: tb/tb_count_reader.sv
// Directed bench for count_reader with hand-computed expected bytes.
module tb_count_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  count_reader_if bus ();
  count_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rd();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic do_mw(input logic [1:0] rw);
    bus.mode_wr = 1'b1;
    bus.rw      = rw;
    tick();
    bus.mode_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    do_rd();
    chk({tag, "_dout"}, {8'h00, bus.dout}, {8'h00, exp});
    chk({tag, "_vld"}, {15'h0, bus.dout_valid}, 16'h0001);
  endtask

  initial begin
    bus.count = 16'h0000; bus.mode_wr = 1'b0; bus.rw = 2'b00; bus.rd = 1'b0;
    #23;
    chk("rst_dout", {8'h00, bus.dout}, 16'h0000);
    chk("rst_vld", {15'h0, bus.dout_valid}, 16'h0000);
    chk("rst_latched", {15'h0, bus.latched}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Default mode is LSB-then-MSB straight out of reset
    bus.count = 16'hA55A;
    rd_chk("a55a_lsb", 8'h5A);
    tick();
    chk("vld_drop", {15'h0, bus.dout_valid}, 16'h0000);
    chk("dout_hold", {8'h00, bus.dout}, 16'h005A);
    rd_chk("a55a_msb", 8'hA5);

    // Latched read in mode 11, live count moves underneath
    do_mw(2'b11);
    bus.count = 16'h1234;
    do_mw(2'b00);
    chk("latch_set", {15'h0, bus.latched}, 16'h0001);
    bus.count = 16'h0FFF;
    rd_chk("l1234_lsb", 8'h34);
    chk("latch_mid", {15'h0, bus.latched}, 16'h0001);
    rd_chk("l1234_msb", 8'h12);
    chk("latch_clr", {15'h0, bus.latched}, 16'h0000);

    // Second latch command ignored while one is held
    do_mw(2'b10);
    bus.count = 16'h00FF;
    do_mw(2'b00);
    bus.count = 16'h0100;
    do_mw(2'b00);
    chk("latch2_held", {15'h0, bus.latched}, 16'h0001);
    rd_chk("l00ff_msb", 8'h00);
    chk("latch2_clr", {15'h0, bus.latched}, 16'h0000);
    rd_chk("live_msb", 8'h01);

    // Mode change mid-pair resets pointer
    do_mw(2'b11);
    bus.count = 16'hBEEF;
    rd_chk("beef_lsb", 8'hEF);
    do_mw(2'b01);
    rd_chk("beef_m01", 8'hEF);
    rd_chk("beef_m01b", 8'hEF);

    // Simultaneous mode_wr and rd: read dropped
    do_mw(2'b11);
    rd_chk("beef_lsb2", 8'hEF);
    bus.rd = 1'b1;
    do_mw(2'b10);
    bus.rd = 1'b0;
    chk("coll_vld", {15'h0, bus.dout_valid}, 16'h0000);
    chk("coll_dout", {8'h00, bus.dout}, 16'h00EF);
    rd_chk("coll_next", 8'hBE);

    // Latch command coinciding with rd: latch taken, read dropped
    bus.count = 16'h5AC3;
    bus.rd = 1'b1;
    do_mw(2'b00);
    bus.rd = 1'b0;
    chk("coll2_vld", {15'h0, bus.dout_valid}, 16'h0000);
    chk("coll2_lat", {15'h0, bus.latched}, 16'h0001);
    bus.count = 16'h0000;
    rd_chk("coll2_msb", 8'h5A);

    // Reset mid-sequence with latch held at PTR_MSB
    do_mw(2'b11);
    bus.count = 16'h1357;
    do_mw(2'b00);
    rd_chk("l1357_lsb", 8'h57);
    rst_n = 1'b0;
    #2;
    chk("arst_latched", {15'h0, bus.latched}, 16'h0000);
    chk("arst_dout", {8'h00, bus.dout}, 16'h0000);
    chk("arst_vld", {15'h0, bus.dout_valid}, 16'h0000);
    #3;
    rst_n = 1'b1;
    bus.count = 16'h2468;
    rd_chk("post_rst_lsb", 8'h68);
    chk("post_rst_lat", {15'h0, bus.latched}, 16'h0000);
    rd_chk("post_rst_msb", 8'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/count_reader.md
COUNT_READER -- requirements
Module: count_reader

Interface
REQ-001 Parameters: none; data bus width is fixed at 8 and count width at 16.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 count  input  16  live value of the counter channel's down-counter.
REQ-005 mode_wr  input  1  one-cycle strobe: a control word addressed to this channel is written this cycle.
REQ-006 rw  input  2  RL1:RL0 field of that control word, sampled only when mode_wr=1.
- 00 = counter-latch command.
- 01 = LSB only.
- 10 = MSB only.
- 11 = LSB then MSB.
REQ-007 rd  input  1  one-cycle read strobe from the bus interface for this channel.
REQ-008 dout  output  8  byte returned for the read.
REQ-009 dout_valid  output  1  high for exactly one cycle when dout holds a read result.
REQ-010 latched  output  1  high while a latched count is held and not yet fully read.

Function
REQ-011 Internal state:
- rw_mode (2 bits, never 00).
- 16-bit latch register.
- latch flag.
- byte pointer with states PTR_LSB and PTR_MSB.
REQ-012 Control write with mode_wr=1 and rw≠00:
- rw_mode <= rw.
- Pointer <= PTR_LSB.
- Latch flag cleared.
REQ-013 Control write with mode_wr=1 and rw=00 (latch command):
- If latch flag=0: latch register <= count and latch flag <= 1.
- If latch flag=1: command ignored; held value unchanged.
- rw_mode and pointer are unchanged in both cases.
REQ-014 Read source: latch register when latch flag=1, otherwise the count input sampled in the rd cycle.
REQ-015 Read latency: dout and dout_valid update on the edge ending the rd cycle (1-cycle latency); dout_valid returns to 0 the next cycle unless rd repeats.
REQ-016 rw_mode=01: dout = source[7:0]; pointer stays PTR_LSB; latch flag cleared after the read.
REQ-017 rw_mode=10: dout = source[15:8]; pointer stays PTR_LSB; latch flag cleared after the read.
REQ-018 rw_mode=11 with pointer PTR_LSB: dout = source[7:0]; pointer <= PTR_MSB; latch flag unchanged.
REQ-019 rw_mode=11 with pointer PTR_MSB: dout = source[15:8]; pointer <= PTR_LSB; latch flag cleared after the read.
REQ-020 In rw_mode=11 with no latch, the LSB and MSB are sampled from count at their respective reads; no tear protection is applied.
REQ-021 dout holds its last value while dout_valid=0.
REQ-022 Simultaneous mode_wr=1 and rd=1: mode_wr takes priority.
- rd is dropped; dout_valid=0 next cycle.
- Pointer and latch flag follow REQ-012 or REQ-013 only.
REQ-023 Back-to-back rd on consecutive cycles is legal; each strobe produces one dout_valid pulse and one pointer step.
REQ-024 latched output equals the latch flag (registered, no combinational path from inputs).

Reset
REQ-025 rst_n=0 asynchronously forces:
- dout=8'h00, dout_valid=0, latched=0.
- Latch register=16'h0000.
- rw_mode=11, pointer=PTR_LSB.
REQ-026 Reset asserted mid-sequence (pointer at PTR_MSB, or latch held) discards the partial read; the first read after release returns the LSB of the live count.
REQ-027 Release of rst_n is synchronised externally; the block needs no cycles after release before accepting mode_wr or rd.

Verification
REQ-028 Reset, count=16'hA55A, rd pulse -> dout=8'h5A, dout_valid high one cycle; second rd -> dout=8'hA5.
REQ-029 mode_wr rw=11; count=16'h1234; latch command; count changes to 16'h0FFF; rd, rd -> dout 8'h34 then 8'h12, latched falls after the second read.
REQ-030 Latch at count=16'h00FF, second latch command at count=16'h0100, rd (rw_mode=10) -> dout=8'h00 from the first latch; latched=0 afterwards.
REQ-031 rw_mode=11, one rd (LSB) then mode_wr rw=01 with count=16'hBEEF; rd -> dout=8'hEF, pointer back at PTR_LSB.
REQ-032 mode_wr and rd asserted in the same cycle -> no dout_valid pulse; the next rd returns a byte per the new rw_mode.
REQ-033 Latch held at pointer PTR_MSB, rst_n pulsed low -> latched=0, dout=8'h00; next rd returns LSB of the live count.
